// File: rtl/imem_byte_streamer.sv
// Instruction-memory responder: fetches the bytes of one instruction from a
// byte-wide synchronous memory, one read at a time, and returns the packed
// 80-bit instruct word together with its length, valP and error flags.
module imem_byte_streamer #(
    parameter int MEM_BYTES = 1034,
    parameter int AW        = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_pc,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [79:0]   instruct,
    output logic [3:0]    rsp_len,
    output logic [AW-1:0] valP,
    output logic          mem_err,
    output logic          instr_err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    // One extra bit so that an address computation that wraps AW is still
    // seen as out of range.
    localparam logic [AW:0] MEM_LIMIT = (AW+1)'(MEM_BYTES);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] pc;
    logic [3:0]    len;
    logic [AW:0]   fetch_addr;
    logic          fetch_oob;
    logic [3:0]    dec_len;
    logic          dec_bad;
    logic [3:0]    cur_len;

    // rsp_len doubles as the index of the next byte to fetch.
    assign fetch_addr = {1'b0, pc} + {{(AW-3){1'b0}}, rsp_len};
    assign fetch_oob  = (fetch_addr >= MEM_LIMIT);

    // Length decode from the icode nibble of byte 0 as it arrives.
    always_comb begin
        dec_len = 4'd1;
        dec_bad = 1'b0;
        case (mem_rdata[7:4])
            4'h0, 4'h1, 4'h9:       dec_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: dec_len = 4'd2;
            4'h7, 4'h8:             dec_len = 4'd9;
            4'h3, 4'h4, 4'h5:       dec_len = 4'd10;
            default: begin
                dec_len = 4'd1;
                dec_bad = 1'b1;
            end
        endcase
    end

    // While byte 0 is being captured the stored length is not known yet.
    assign cur_len = (rsp_len == 4'd0) ? dec_len : len;

    // Next-state and handshake/memory strobes; strobes derive from state so
    // reset drops them in the same instant.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (fetch_oob) begin
                    state_next = RESP;
                end else begin
                    mem_rd_en  = 1'b1;
                    mem_addr   = fetch_addr[AW-1:0];
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (rsp_len + 4'd1 == cur_len) begin
                    state_next = RESP;
                end else begin
                    state_next = ISSUE;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request latch, byte capture and response fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            len       <= 4'd0;
            instruct  <= '0;
            rsp_len   <= 4'd0;
            valP      <= '0;
            mem_err   <= 1'b0;
            instr_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        pc        <= req_pc;
                        len       <= 4'd0;
                        instruct  <= '0;
                        rsp_len   <= 4'd0;
                        valP      <= '0;
                        mem_err   <= 1'b0;
                        instr_err <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (fetch_oob) begin
                        mem_err <= 1'b1;
                        if (rsp_len == 4'd0) begin
                            valP <= pc + {{(AW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                CAPTURE: begin
                    for (int i = 0; i < 10; i++) begin
                        if (rsp_len == 4'(i)) begin
                            instruct[79-8*i -: 8] <= mem_rdata;
                        end
                    end
                    rsp_len <= rsp_len + 4'd1;
                    if (rsp_len == 4'd0) begin
                        len       <= dec_len;
                        valP      <= pc + {{(AW-4){1'b0}}, dec_len};
                        instr_err <= dec_bad;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_byte_streamer.sv
// Self-checking bench for imem_byte_streamer: a byte-array memory model feeds
// the DUT and every response is compared with a reference computed directly
// from the instruction-length rules.
module tb_imem_byte_streamer;

    localparam int MEM_BYTES = 1034;
    localparam int AW        = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_pc;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [79:0]   instruct;
    logic [3:0]    rsp_len;
    logic [AW-1:0] valP;
    logic          mem_err;
    logic          instr_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] mem [0:MEM_BYTES-1];
    int         rd_total = 0;
    int         bad_addr = 0;

    logic [79:0]   got_instruct;
    logic [3:0]    got_len;
    logic [AW-1:0] got_valp;
    logic          got_merr;
    logic          got_ierr;
    int            got_lat;
    int            got_reads;

    imem_byte_streamer #(.MEM_BYTES(MEM_BYTES), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pc    (req_pc),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .instruct  (instruct),
        .rsp_len   (rsp_len),
        .valP      (valP),
        .mem_err   (mem_err),
        .instr_err (instr_err)
    );

    always #5 clk = ~clk;

    // Synchronous byte memory: data one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            if (mem_addr < 64'(MEM_BYTES)) begin
                mem_rdata <= mem[mem_addr[10:0]];
            end else begin
                mem_rdata <= 8'hEE;
            end
        end
    end

    // Read-strobe bookkeeping.
    always @(posedge clk) begin
        if (rst_n && mem_rd_en) begin
            rd_total <= rd_total + 1;
            if (mem_addr >= 64'(MEM_BYTES)) begin
                bad_addr <= bad_addr + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: what fetch should see for an instruction at pc.
    function automatic void refModel(input logic [63:0] pc, output logic [79:0] ins, output int n,
                                     output logic [63:0] vp, output logic me, output logic ie);
        int dl;
        int base;
        logic [3:0] icode;
        ins = '0;
        n   = 0;
        ie  = 1'b0;
        me  = 1'b0;
        if (pc >= 64'(MEM_BYTES)) begin
            me = 1'b1;
            vp = pc + 64'd1;
            return;
        end
        base  = int'(pc);
        icode = mem[base][7:4];
        case (icode)
            4'h0, 4'h1, 4'h9:       dl = 1;
            4'h2, 4'h6, 4'hA, 4'hB: dl = 2;
            4'h7, 4'h8:             dl = 9;
            4'h3, 4'h4, 4'h5:       dl = 10;
            default:                dl = 1;
        endcase
        ie = (icode > 4'hB);
        vp = pc + 64'(dl);
        n  = (base + dl > MEM_BYTES) ? MEM_BYTES - base : dl;
        me = (n < dl);
        for (int i = 0; i < n; i++) begin
            ins[79-8*i -: 8] = mem[base+i];
        end
    endfunction

    task automatic checkReset(input string tag);
        checkOutput({tag, " req_ready"}, 80'(req_ready), 80'd1);
        checkOutput({tag, " mem_rd_en"}, 80'(mem_rd_en), 80'd0);
        checkOutput({tag, " mem_addr"},  80'(mem_addr),  80'd0);
        checkOutput({tag, " rsp_valid"}, 80'(rsp_valid), 80'd0);
        checkOutput({tag, " instruct"},  instruct,       80'd0);
        checkOutput({tag, " rsp_len"},   80'(rsp_len),   80'd0);
        checkOutput({tag, " valP"},      80'(valP),      80'd0);
        checkOutput({tag, " mem_err"},   80'(mem_err),   80'd0);
        checkOutput({tag, " instr_err"}, 80'(instr_err), 80'd0);
    endtask

    // One full fetch: request, wait for response, compare, hold, handshake.
    task automatic applyStimulus(input logic [63:0] pc, input int hold);
        logic [79:0] e_ins;
        int          e_n;
        logic [63:0] e_vp;
        logic        e_me;
        logic        e_ie;
        int          r0;
        int          e_lat;
        bit          got;
        refModel(pc, e_ins, e_n, e_vp, e_me, e_ie);
        e_lat = e_me ? 2 * e_n + 1 : 2 * e_n;
        @(negedge clk);
        checkOutput("idle req_ready", 80'(req_ready), 80'd1);
        req_pc    = pc;
        req_valid = 1'b1;
        r0        = rd_total;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_pc    = {$urandom, $urandom};
        checkOutput("busy req_ready", 80'(req_ready), 80'd0);
        got     = 1'b0;
        got_lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                got     = 1'b1;
                got_lat = i;
                break;
            end
        end
        checkOutput("rsp timeout", 80'(got), 80'd1);
        if (!got) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
            return;
        end
        got_instruct = instruct;
        got_len      = rsp_len;
        got_valp     = valP;
        got_merr     = mem_err;
        got_ierr     = instr_err;
        got_reads    = rd_total - r0;
        checkOutput("latency",   80'(got_lat),   80'(e_lat));
        checkOutput("instruct",  instruct,       e_ins);
        checkOutput("rsp_len",   80'(rsp_len),   80'(e_n));
        checkOutput("valP",      80'(valP),      80'(e_vp));
        checkOutput("mem_err",   80'(mem_err),   80'(e_me));
        checkOutput("instr_err", 80'(instr_err), 80'(e_ie));
        checkOutput("reads",     80'(got_reads), 80'(e_n));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold rsp_valid", 80'(rsp_valid), 80'd1);
            checkOutput("hold req_ready", 80'(req_ready), 80'd0);
            checkOutput("hold instruct",  instruct,       e_ins);
            checkOutput("hold valP",      80'(valP),      80'(e_vp));
            checkOutput("hold rsp_len",   80'(rsp_len),   80'(e_n));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checkOutput("post-hs rsp_valid", 80'(rsp_valid), 80'd0);
        checkOutput("post-hs req_ready", 80'(req_ready), 80'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_pc    = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            mem[i] = 8'($urandom);
        end
        // Directed program bytes.
        mem[0]  = 8'h00;
        mem[2]  = 8'h20;
        mem[3]  = 8'h03;
        mem[5]  = 8'hF0;
        mem[66] = 8'h35;
        mem[67] = 8'h53;
        for (int i = 68; i < 75; i++) begin
            mem[i] = 8'h00;
        end
        mem[75]   = 8'h06;
        mem[1030] = 8'h30;

        #12;
        checkReset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // irmovq, full 10 bytes
        applyStimulus(64'd66, 0);
        checkOutput("t1 instruct", got_instruct, 80'h3553_0000_0000_0000_0006);
        checkOutput("t1 len",      80'(got_len), 80'd10);
        checkOutput("t1 valP",     80'(got_valp), 80'd76);
        checkOutput("t1 latency",  80'(got_lat), 80'd20);
        checkOutput("t1 reads",    80'(got_reads), 80'd10);

        // rrmovq
        applyStimulus(64'd2, 1);
        checkOutput("t2 instruct", got_instruct, 80'h2003_0000_0000_0000_0000);
        checkOutput("t2 len",      80'(got_len), 80'd2);
        checkOutput("t2 valP",     80'(got_valp), 80'd4);
        checkOutput("t2 reads",    80'(got_reads), 80'd2);

        // halt
        applyStimulus(64'd0, 0);
        checkOutput("t3 instruct", got_instruct, 80'd0);
        checkOutput("t3 len",      80'(got_len), 80'd1);
        checkOutput("t3 valP",     80'(got_valp), 80'd1);
        checkOutput("t3 latency",  80'(got_lat), 80'd2);
        checkOutput("t3 errs",     80'({got_merr, got_ierr}), 80'd0);

        // illegal icode
        applyStimulus(64'd5, 0);
        checkOutput("t4 instruct", got_instruct, {8'hF0, 72'd0});
        checkOutput("t4 len",      80'(got_len), 80'd1);
        checkOutput("t4 valP",     80'(got_valp), 80'd6);
        checkOutput("t4 errs",     80'({got_merr, got_ierr}), 80'b01);

        // irmovq running off the end of memory
        applyStimulus(64'd1030, 0);
        checkOutput("t5 len",     80'(got_len), 80'd4);
        checkOutput("t5 valP",    80'(got_valp), 80'd1040);
        checkOutput("t5 mem_err", 80'(got_merr), 80'd1);
        checkOutput("t5 latency", 80'(got_lat), 80'd9);

        // Request entirely out of range, including an address that wraps AW.
        applyStimulus(64'd1034, 0);
        checkOutput("oob len",  80'(got_len), 80'd0);
        checkOutput("oob valP", 80'(got_valp), 80'd1035);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 0);
        checkOutput("wrap valP",    80'(got_valp), 80'd0);
        checkOutput("wrap mem_err", 80'(got_merr), 80'd1);

        // Long stall in RESP, then reset in the middle of the next fetch.
        applyStimulus(64'd66, 5);
        @(negedge clk);
        req_pc    = 64'd66;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkReset("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(64'd66, 0);
        checkOutput("after reset instruct", got_instruct, 80'h3553_0000_0000_0000_0006);

        // Randomized fetches across the whole address range.
        for (int t = 0; t < 40; t++) begin
            applyStimulus(64'($urandom_range(0, MEM_BYTES + 5)), int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        checkOutput("no out-of-range reads", 80'(bad_addr), 80'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
